// File: rtl/sec_encoder_stream.sv
// sec_encoder_stream
// Streaming SEC check-bit generator for the 32-data/8-check corrector.
// Two-stage elastic pipeline: S1 captures the raw word, S2 computes the
// check bits, applies the optional single-bit fault flip and holds the
// 40-bit codeword until downstream takes it.

module sec_encoder_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_inj_en,
  input  logic [5:0]       in_inj_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_check,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] inj_cnt
);

  // Data-bit coverage of each check bit; every mask selects 12 bits and
  // every data bit appears in exactly three masks with a unique pattern,
  // which is what lets the corrector locate a single flipped bit.
  localparam logic [31:0] MASK_C0 = 32'h00FF_1111;
  localparam logic [31:0] MASK_C1 = 32'hFF00_2222;
  localparam logic [31:0] MASK_C2 = 32'h0F0F_4444;
  localparam logic [31:0] MASK_C3 = 32'hF0F0_8888;
  localparam logic [31:0] MASK_C4 = 32'h1111_00FF;
  localparam logic [31:0] MASK_C5 = 32'h2222_FF00;
  localparam logic [31:0] MASK_C6 = 32'h4444_0F0F;
  localparam logic [31:0] MASK_C7 = 32'h8888_F0F0;

  // Codeword bit positions 40 and above mean "no flip".
  localparam logic [5:0] CW_BITS = 6'd40;

  function automatic logic [7:0] gen_check(input logic [31:0] d);
    logic [7:0] c;
    c[0] = ^(d & MASK_C0);
    c[1] = ^(d & MASK_C1);
    c[2] = ^(d & MASK_C2);
    c[3] = ^(d & MASK_C3);
    c[4] = ^(d & MASK_C4);
    c[5] = ^(d & MASK_C5);
    c[6] = ^(d & MASK_C6);
    c[7] = ^(d & MASK_C7);
    return c;
  endfunction

  logic        s1_v;
  logic [31:0] s1_data;
  logic        s1_inj_en;
  logic [5:0]  s1_inj_pos;

  logic        s2_v;
  logic [31:0] s2_data;
  logic [7:0]  s2_check;
  logic        s2_inj;

  logic        s2_load;
  logic        s1_load;
  logic        s2_apply;
  logic [39:0] s2_flip;
  logic [39:0] s2_next;
  logic        out_fire;

  // Ready chain: a stage can take new contents when empty or draining now.
  always_comb begin
    s2_load  = !s2_v || out_ready;
    s1_load  = !s1_v || s2_load;
    in_ready = s1_load;
    out_fire = s2_v && out_ready;
  end

  // Check bits come from the clean data; the fault flip is applied on top.
  always_comb begin
    s2_flip  = 40'd0;
    s2_apply = s1_inj_en && (s1_inj_pos < CW_BITS);
    if (s2_apply) begin
      s2_flip = 40'd1 << s1_inj_pos;
    end
    s2_next = {gen_check(s1_data), s1_data} ^ s2_flip;
  end

  // Stage 1: capture the incoming word and its injection request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s1_data    <= 32'd0;
      s1_inj_en  <= 1'b0;
      s1_inj_pos <= 6'd0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_data    <= in_data;
        s1_inj_en  <= in_inj_en;
        s1_inj_pos <= in_inj_pos;
      end
    end
  end

  // Stage 2: hold the finished codeword until the output transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v     <= 1'b0;
      s2_data  <= 32'd0;
      s2_check <= 8'd0;
      s2_inj   <= 1'b0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_data  <= s2_next[31:0];
        s2_check <= s2_next[39:32];
        s2_inj   <= s2_apply;
      end
    end
  end

  // Transfer counters, wrapping naturally at the counter width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      inj_cnt  <= '0;
    end else if (out_fire) begin
      word_cnt <= word_cnt + 1'b1;
      if (s2_inj) begin
        inj_cnt <= inj_cnt + 1'b1;
      end
    end
  end

  assign out_valid = s2_v;
  assign out_data  = s2_data;
  assign out_check = s2_check;

endmodule

// File: tb/tb_sec_encoder_stream.sv
// tb_sec_encoder_stream
// Directed vectors for sec_encoder_stream plus a randomized stream that is
// run through a behavioural corrector built from the check-bit lists.

module tb_sec_encoder_stream;

  localparam int CNT_W = 16;
  localparam int NRAND = 10000;
  localparam int MAXCYC = 60000;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_inj_en;
  logic [5:0]       in_inj_pos;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [7:0]       out_check;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] inj_cnt;

  int vectors = 0;
  int miscompares = 0;

  sec_encoder_stream #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inj_en (in_inj_en),
    .in_inj_pos(in_inj_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_check (out_check),
    .word_cnt  (word_cnt),
    .inj_cnt   (inj_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Membership of data bit k in check c, written from the range lists.
  function automatic bit inCheck(input int c, input int k);
    case (c)
      0: return (k < 16 && k % 4 == 0) || (k >= 16 && k <= 23);
      1: return (k < 16 && k % 4 == 1) || (k >= 24);
      2: return (k < 16 && k % 4 == 2) || (k >= 16 && k <= 19) || (k >= 24 && k <= 27);
      3: return (k < 16 && k % 4 == 3) || (k >= 20 && k <= 23) || (k >= 28);
      4: return (k <= 7) || (k >= 16 && k % 4 == 0);
      5: return (k >= 8 && k <= 15) || (k >= 16 && k % 4 == 1);
      6: return (k <= 3) || (k >= 8 && k <= 11) || (k >= 16 && k % 4 == 2);
      7: return (k >= 4 && k <= 7) || (k >= 12 && k <= 15) || (k >= 16 && k % 4 == 3);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] modelCheck(input logic [31:0] d);
    logic [7:0] c;
    c = 8'd0;
    for (int ci = 0; ci < 8; ci++) begin
      for (int k = 0; k < 32; k++) begin
        if (inCheck(ci, k)) c[ci] = c[ci] ^ d[k];
      end
    end
    return c;
  endfunction

  // Behavioural single-error corrector: returns the repaired data word.
  function automatic logic [31:0] correctWord(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  syn;
    logic [31:0] one;
    syn = modelCheck(d) ^ c;
    if (syn == 8'd0) return d;
    for (int j = 0; j < 32; j++) begin
      one = 32'd1 << j;
      if (modelCheck(one) == syn) return d ^ one;
    end
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    in_valid  = 1'b0;
    in_inj_en = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Send one word with the output side open and check latency and codeword.
  task automatic applyStimulus(input string tag, input logic [31:0] d, input logic en,
                               input logic [5:0] pos, input logic [31:0] expData,
                               input logic [7:0] expChk);
    @(negedge clk);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_data    = d;
    in_inj_en  = en;
    in_inj_pos = pos;
    #1;
    checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_inj_en = 1'b0;
    checkOutput({tag, " early valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, " out_data"}, 64'(out_data), 64'(expData));
    checkOutput({tag, " out_check"}, 64'(out_check), 64'(expChk));
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] ent;
    logic [5:0]  rpos;
    logic        ren;
    int sent, recv, cyc, expInj;
    bit accepted;

    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = 32'd0;
    in_inj_en  = 1'b0;
    in_inj_pos = 6'd0;
    out_ready  = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset out_data", 64'(out_data), 64'd0);
    checkOutput("reset out_check", 64'(out_check), 64'd0);
    checkOutput("reset word_cnt", 64'(word_cnt), 64'd0);
    checkOutput("reset inj_cnt", 64'(inj_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain encoding of hand-computed words.
    applyStimulus("zero", 32'h0000_0000, 1'b0, 6'd0, 32'h0000_0000, 8'h00);
    applyStimulus("d0",   32'h0000_0001, 1'b0, 6'd0, 32'h0000_0001, 8'h51);
    applyStimulus("d16",  32'h0001_0000, 1'b0, 6'd0, 32'h0001_0000, 8'h15);
    applyStimulus("d31",  32'h8000_0000, 1'b0, 6'd0, 32'h8000_0000, 8'h8A);
    applyStimulus("ones", 32'hFFFF_FFFF, 1'b0, 6'd0, 32'hFFFF_FFFF, 8'h00);
    @(negedge clk);
    checkOutput("plain word_cnt", 64'(word_cnt), 64'd5);
    checkOutput("plain inj_cnt", 64'(inj_cnt), 64'd0);

    // Fault injection: check-bit flip, data-bit flip, out-of-range position.
    resetDut();
    applyStimulus("inj c3", 32'h0000_0000, 1'b1, 6'd35, 32'h0000_0000, 8'h08);
    applyStimulus("inj d5", 32'h0000_0000, 1'b1, 6'd5,  32'h0000_0020, 8'h00);
    applyStimulus("inj 45", 32'h0000_0001, 1'b1, 6'd45, 32'h0000_0001, 8'h51);
    @(negedge clk);
    checkOutput("inj word_cnt", 64'(word_cnt), 64'd3);
    checkOutput("inj inj_cnt", 64'(inj_cnt), 64'd2);

    // Backpressure: four words, output blocked for three rising edges.
    resetDut();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0001;
    @(negedge clk);
    in_data = 32'h0001_0000;
    @(negedge clk);
    in_data = 32'h8000_0000;
    checkOutput("bp full in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp w0 data", 64'(out_data), 64'h0000_0001);
    @(negedge clk);
    checkOutput("bp hold in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp hold data", 64'(out_data), 64'h0000_0001);
    checkOutput("bp hold check", 64'(out_check), 64'h51);
    out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_data = 32'hFFFF_FFFF;
    checkOutput("bp w1 data", 64'(out_data), 64'h0001_0000);
    checkOutput("bp w1 check", 64'(out_check), 64'h15);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp w2 data", 64'(out_data), 64'h8000_0000);
    checkOutput("bp w2 check", 64'(out_check), 64'h8A);
    @(negedge clk);
    checkOutput("bp w3 valid", 64'(out_valid), 64'd1);
    checkOutput("bp w3 data", 64'(out_data), 64'hFFFF_FFFF);
    checkOutput("bp w3 check", 64'(out_check), 64'h00);
    @(negedge clk);
    checkOutput("bp drained", 64'(out_valid), 64'd0);
    checkOutput("bp word_cnt", 64'(word_cnt), 64'd4);

    // Reset with two words held in the pipeline.
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_inj_en  = 1'b1;
    in_inj_pos = 6'd2;
    in_data    = 32'h0000_0001;
    @(negedge clk);
    in_data = 32'h0001_0000;
    @(negedge clk);
    in_valid  = 1'b0;
    in_inj_en = 1'b0;
    checkOutput("mid in flight", 64'(out_valid), 64'd1);
    checkOutput("mid in_ready", 64'(in_ready), 64'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid rst out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid rst in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid rst word_cnt", 64'(word_cnt), 64'd0);
    checkOutput("mid rst inj_cnt", 64'(inj_cnt), 64'd0);
    checkOutput("mid rst out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("post rst no output", 64'(out_valid), 64'd0);
    applyStimulus("post rst", 32'h8000_0000, 1'b0, 6'd0, 32'h8000_0000, 8'h8A);

    // Randomized stream through the behavioural corrector.
    resetDut();
    sent = 0;
    recv = 0;
    cyc = 0;
    expInj = 0;
    accepted = 1'b0;
    while (recv < NRAND && cyc < MAXCYC) begin
      @(negedge clk);
      cyc++;
      if (accepted) begin
        in_valid  = 1'b0;
        in_inj_en = 1'b0;
        accepted  = 1'b0;
      end
      if (!in_valid && sent < NRAND && $urandom_range(0, 7) != 0) begin
        ren  = 1'($urandom_range(0, 1));
        rpos = 6'($urandom_range(0, 63));
        in_valid   = 1'b1;
        in_data    = $urandom;
        in_inj_en  = ren;
        in_inj_pos = rpos;
        sent++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checkOutput("rand spurious output", 64'(out_valid), 64'd0);
        end else begin
          ent = q.pop_front();
          if (ent[32]) begin
            checkOutput("rand corrected", 64'(correctWord(out_data, out_check)), 64'(ent[31:0]));
          end else begin
            checkOutput("rand clean", {24'd0, out_check, out_data},
                        {24'd0, modelCheck(ent[31:0]), ent[31:0]});
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        ent = {in_inj_en && (in_inj_pos < 6'd40), in_data};
        if (ent[32]) expInj++;
        q.push_back(ent);
        accepted = 1'b1;
      end
    end
    checkOutput("rand words received", 64'(recv), 64'(NRAND));
    @(negedge clk);
    checkOutput("rand word_cnt", 64'(word_cnt), 64'(NRAND % (1 << CNT_W)));
    checkOutput("rand inj_cnt", 64'(inj_cnt), 64'(expInj % (1 << CNT_W)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sec_encoder_stream.md
# sec_encoder_stream

Streaming single-error-correcting (SEC) check-bit generator: the write-side counterpart of the team's 32-data/8-check SEC corrector. Accepts 32-bit data words over a valid/ready handshake and produces 40-bit codewords (data plus 8 check bits) through a 2-stage elastic pipeline. The check bits are exactly those the corrector expects on its check inputs, so an error-free codeword decodes with zero syndrome. A per-word fault-injection path flips one chosen codeword bit so the corrector can be exercised in-system.

## Interface
- CNT_W, default 16: width of the transfer and injection counters.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept the input word this cycle.
- in_data  in  32  data word; d[k] = in_data[k].
- in_inj_en  in  1  flip one codeword bit for this word.
- in_inj_pos  in  6  bit to flip: 0..31 = data bit, 32..39 = check bit c[pos-32]; 40..63 = no flip.
- out_valid  out  1  codeword present.
- out_ready  in  1  downstream accepts the codeword.
- out_data  out  32  data part of the codeword.
- out_check  out  8  check bits c0..c7; c[k] drives corrector check input k.
- word_cnt  out  CNT_W  count of completed output transfers.
- inj_cnt  out  CNT_W  count of completed output transfers whose flip was actually applied.

## Operation
- Check equations, with XOR over the listed data bits:
  - c0 = d0,d4,d8,d12,d16..d23
  - c1 = d1,d5,d9,d13,d24..d31
  - c2 = d2,d6,d10,d14,d16..d19,d24..d27
  - c3 = d3,d7,d11,d15,d20..d23,d28..d31
  - c4 = d0..d7,d16,d20,d24,d28
  - c5 = d8..d15,d17,d21,d25,d29
  - c6 = d0..d3,d8..d11,d18,d22,d26,d30
  - c7 = d4..d7,d12..d15,d19,d23,d27,d31
- Each check bit covers 12 data bits.
- Stage 1 (S1) registers in_data, in_inj_en and in_inj_pos.
- Stage 2 (S2) computes the check bits from the clean S1 data, applies the injection flip, and registers the 40-bit result.
- The flip is applied after check generation:
  - a data-bit flip leaves out_check clean;
  - a check-bit flip leaves out_data clean.
- Each stage holds a valid flag. A stage loads when it is empty or when its contents move on in the same cycle.
  - s2_load = !s2_v | out_ready
  - s1_load = !s1_v | s2_load
  - in_ready = s1_load
- The ready chain is combinational. There is no bubble at full throughput.
- A transfer completes when valid and ready are both high in the same cycle.
- word_cnt increments on each output transfer. inj_cnt increments on each output transfer where in_inj_en was set and in_inj_pos < 40. Both counters wrap modulo 2^CNT_W.

## Timing
- Reset (asynchronous assert, takes effect without waiting for a clock edge):
  - s1_v = s2_v = 0, so out_valid = 0 and in_ready = 1;
  - out_data = 0, out_check = 0, word_cnt = 0, inj_cnt = 0.
- Reset mid-stream discards both in-flight words. No partial output appears after reset is released.
- Latency: a word accepted at edge N is presented on out_* after edge N+1 and is valid from that cycle onward.
- Throughput: 1 word/cycle while out_ready = 1.
- While out_valid = 1 and out_ready = 0, out_data and out_check stay stable.
- With out_ready low, up to 2 words are buffered. in_ready falls when both stages are full.
- Simultaneous accept at input and output while full: both transfers happen and no word is lost.
- When out_ready rises, in_ready rises in the same cycle.
- Word order is preserved. No word is duplicated or dropped.

## Test plan
- Reset, then in_data = 0x00000000 with no injection -> out_data 0x00000000, out_check 0x00, out_valid 2 edges after accept.
- in_data 0x00000001 -> out_check 0x51; 0x00010000 -> 0x15; 0x80000000 -> 0x8A; 0xFFFFFFFF -> 0x00. Each result goes through the corrector unchanged, with zero syndrome.
- Injection:
  - data 0, inj_pos 35 -> out_data 0, out_check 0x08;
  - data 0, inj_pos 5 -> out_data 0x00000020, out_check 0x00;
  - inj_pos 45 -> no flip.
  - inj_cnt ends at 2 and word_cnt at 3.
- Back-to-back stream of 4 words with out_ready held low for 3 cycles:
  - in_ready goes low once 2 words are held;
  - all 4 words emerge in order with correct checks;
  - word_cnt = 4.
- Assert rst for 1 cycle while 2 words are in flight -> out_valid drops at once and both counters read 0. The next word after release emerges correctly 2 edges after accept.
- Random data and random injection for 10k words fed into the corrector:
  - no injection -> output equals input;
  - any single flip -> corrected output equals the original data.
